// File: rtl/motor_cmd_pkg.sv
// Shared frame constants, parser state encoding and frame payload type.
package motor_cmd_pkg;

  localparam logic [7:0] HDR1_BYTE = 8'hEB;
  localparam logic [7:0] HDR2_BYTE = 8'h90;
  localparam logic [7:0] CMD_MOVE  = 8'h01;

  // Unused codes fall back to IDLE in the next-state logic.
  (* fsm_encoding = "safe", fsm_safe_state = "reset_state" *)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR2  = 3'd1,
    ST_CMD   = 3'd2,
    ST_PARAM = 3'd3,
    ST_CSUM  = 3'd4
  } parse_state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] param;
  } frame_s;

  // Checksum is the 8-bit wrapped sum of CMD and PARAM.
  function automatic logic csum_ok(input frame_s frame, input logic [7:0] csum);
    logic [7:0] sum;
    sum = frame.cmd + frame.param;
    return sum == csum;
  endfunction

endpackage

// File: rtl/limit_debounce.sv
// Two-flop synchroniser plus consecutive-sample debounce for one limit switch.
module limit_debounce #(
  parameter int unsigned debounce_cycles = 100000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CNT_W = (debounce_cycles > 1) ? $clog2(debounce_cycles + 1) : 1;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous switch level into the sys_clk domain.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that differ from the output; any agreement restarts the count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_o <= 1'b0;
    end else if (sync_q2 == level_o) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(debounce_cycles - 1)) begin
      cnt_q   <= '0;
      level_o <= sync_q2;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/motor_cmd_parser.sv
// Serial command frame parser driving the motor controller, plus debounced limit switches.
module motor_cmd_parser
  import motor_cmd_pkg::*;
#(
  parameter int unsigned clk_freq        = 100,
  parameter int unsigned byte_timeout_us = 1000,
  parameter int unsigned debounce_cycles = 100000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       motor_busy_i,
  input  logic       left_limit_raw_i,
  input  logic       right_limit_raw_i,
  output logic       motor_start_o,
  output logic [7:0] step_volumn_o,
  output logic       left_limit_o,
  output logic       right_limit_o,
  output logic       frame_ok_o,
  output logic       frame_err_o
);

  localparam int unsigned TIMEOUT_CYCLES = byte_timeout_us * clk_freq;
  localparam int unsigned GAP_W          = $clog2(TIMEOUT_CYCLES + 1);

  (* fsm_encoding = "safe" *) parse_state_e state_q;
  parse_state_e state_d;

  frame_s           frame_q;
  frame_s           frame_d;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [GAP_W-1:0] gap_cnt_d;
  logic             start_d;
  logic             ok_d;
  logic             err_d;
  logic [7:0]       step_d;
  logic             timeout_c;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_c = (state_q != ST_IDLE) && !rx_valid_i &&
                     (gap_cnt_q == GAP_W'(TIMEOUT_CYCLES - 1));

  // Parser state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: advance only on accepted bytes, or drop back to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    if (rx_valid_i) begin
      case (state_q)
        ST_IDLE:  state_d = (rx_data_i == HDR1_BYTE) ? ST_HDR2 : ST_IDLE;
        ST_HDR2: begin
          if (rx_data_i == HDR2_BYTE)      state_d = ST_CMD;
          else if (rx_data_i == HDR1_BYTE) state_d = ST_HDR2;
          else                             state_d = ST_IDLE;
        end
        ST_CMD:   state_d = ST_PARAM;
        ST_PARAM: state_d = ST_CSUM;
        ST_CSUM:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (timeout_c || (state_q > ST_CSUM)) begin
      state_d = ST_IDLE;
    end
  end

  // Output/datapath: byte latching, gap counter, frame verdict.
  always_comb begin
    frame_d   = frame_q;
    gap_cnt_d = gap_cnt_q;
    start_d   = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    step_d    = step_volumn_o;

    if (state_q == ST_IDLE || rx_valid_i || timeout_c) gap_cnt_d = '0;
    else                                               gap_cnt_d = gap_cnt_q + GAP_W'(1);

    if (rx_valid_i) begin
      case (state_q)
        ST_CMD:   frame_d.cmd   = rx_data_i;
        ST_PARAM: frame_d.param = rx_data_i;
        ST_CSUM: begin
          if (csum_ok(frame_q, rx_data_i) && (frame_q.cmd == CMD_MOVE) && !motor_busy_i) begin
            start_d = 1'b1;
            ok_d    = 1'b1;
            step_d  = frame_q.param;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout_c) begin
      err_d = 1'b1;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q       <= '0;
      gap_cnt_q     <= '0;
      motor_start_o <= 1'b0;
      frame_ok_o    <= 1'b0;
      frame_err_o   <= 1'b0;
      step_volumn_o <= 8'h00;
    end else begin
      frame_q       <= frame_d;
      gap_cnt_q     <= gap_cnt_d;
      motor_start_o <= start_d;
      frame_ok_o    <= ok_d;
      frame_err_o   <= err_d;
      step_volumn_o <= step_d;
    end
  end

  limit_debounce #(.debounce_cycles(debounce_cycles)) u_left_debounce (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .raw_i   (left_limit_raw_i),
    .level_o (left_limit_o)
  );

  limit_debounce #(.debounce_cycles(debounce_cycles)) u_right_debounce (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .raw_i   (right_limit_raw_i),
    .level_o (right_limit_o)
  );

endmodule

// File: tb/tb_motor_cmd_parser.sv
// Scoreboard bench for motor_cmd_parser: driver queues expected strobes, monitor checks them.
module tb_motor_cmd_parser;

  localparam int unsigned T  = 200;   // timeout cycles: clk_freq 1 * 200 us
  localparam int unsigned DB = 100;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       motor_busy_i = 1'b0;
  logic       left_limit_raw_i = 1'b0;
  logic       right_limit_raw_i = 1'b0;
  logic       motor_start_o;
  logic [7:0] step_volumn_o;
  logic       left_limit_o;
  logic       right_limit_o;
  logic       frame_ok_o;
  logic       frame_err_o;

  motor_cmd_parser #(
    .clk_freq(1), .byte_timeout_us(T), .debounce_cycles(DB)
  ) dut (
    .sys_clk           (sys_clk),
    .rst_n             (rst_n),
    .rx_data_i         (rx_data_i),
    .rx_valid_i        (rx_valid_i),
    .motor_busy_i      (motor_busy_i),
    .left_limit_raw_i  (left_limit_raw_i),
    .right_limit_raw_i (right_limit_raw_i),
    .motor_start_o     (motor_start_o),
    .step_volumn_o     (step_volumn_o),
    .left_limit_o      (left_limit_o),
    .right_limit_o     (right_limit_o),
    .frame_ok_o        (frame_ok_o),
    .frame_err_o       (frame_err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    bit         ok;
    bit         err;
    bit         start;
    logic [7:0] step;
    int         at;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] model_step = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop one expectation per strobe cycle, and track the held step value.
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (frame_ok_o || frame_err_o || motor_start_o) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_strobe: ok=%b err=%b start=%b at cycle %0d, none expected",
                   frame_ok_o, frame_err_o, motor_start_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("frame_ok",    32'(frame_ok_o),    32'(mon_e.ok));
          check("frame_err",   32'(frame_err_o),   32'(mon_e.err));
          check("motor_start", 32'(motor_start_o), 32'(mon_e.start));
          check("strobe_cycle", 32'(cyc),          32'(mon_e.at));
          model_step = mon_e.step;
        end
      end
      check("step_volumn", 32'(step_volumn_o), 32'(model_step));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic push(input bit ok, input bit err, input bit start, input logic [7:0] step, input int at);
    exp_t e;
    e.ok = ok; e.err = err; e.start = start; e.step = step; e.at = at;
    sb.push_back(e);
  endtask

  // Full frame with hand-computed verdict and resulting step value.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] param, input logic [7:0] csum,
                       input bit busy, input bit ok, input logic [7:0] step);
    send(8'hEB);
    send(8'h90);
    send(cmd);
    send(param);
    motor_busy_i = busy;
    push(ok, !ok, ok, step, cyc + 1);
    send(csum);
    motor_busy_i = 1'b0;
    idle(3);
  endtask

  task automatic pulse_reset(input int n);
    rst_n      = 1'b0;
    model_step = 8'h00;
    idle(n);
    rst_n = 1'b1;
    idle(1);
  endtask

  int rise;
  int last;
  int lat;

  initial begin
    idle(3);
    check("rst_start",  32'(motor_start_o), 32'h0);
    check("rst_ok",     32'(frame_ok_o),    32'h0);
    check("rst_err",    32'(frame_err_o),   32'h0);
    check("rst_left",   32'(left_limit_o),  32'h0);
    check("rst_right",  32'(right_limit_o), 32'h0);
    check("rst_step",   32'(step_volumn_o), 32'h0);
    rst_n = 1'b1;
    idle(2);

    frame(8'h01, 8'h10, 8'h11, 1'b0, 1'b1, 8'h10);   // good move
    frame(8'h01, 8'h10, 8'h12, 1'b0, 1'b0, 8'h10);   // bad checksum, step held
    send(8'hEB);                                       // EB EB 90 ... resync
    frame(8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF);   // checksum wraps
    frame(8'h02, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFF);   // unknown command
    frame(8'h01, 8'h20, 8'h21, 1'b1, 1'b0, 8'hFF);   // busy motor
    frame(8'h01, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00);   // zero step accepted

    send(8'h55); send(8'hAA); send(8'h90);            // noise in IDLE, no strobe
    send(8'hEB); send(8'h12);                          // bad second header
    idle(T + 5);                                       // no timeout from IDLE
    frame(8'h01, 8'h33, 8'h34, 1'b0, 1'b1, 8'h33);

    // Timeout after CMD byte
    send(8'hEB); send(8'h90); send(8'h01);
    push(1'b0, 1'b1, 1'b0, 8'h33, cyc + T);
    idle(T + 3);
    frame(8'h01, 8'h44, 8'h45, 1'b0, 1'b1, 8'h44);

    // Byte on the expiry cycle beats the timeout
    send(8'hEB); send(8'h90); send(8'h01);
    idle(T - 1);
    send(8'h10);
    push(1'b1, 1'b0, 1'b1, 8'h10, cyc + 1);
    send(8'h11);
    idle(3);

    // Reset mid-frame discards it
    send(8'hEB); send(8'h90); send(8'h01);
    pulse_reset(2);
    check("rst_mid_step", 32'(step_volumn_o), 32'h0);
    frame(8'h01, 8'h66, 8'h67, 1'b0, 1'b1, 8'h66);

    // Bouncing right limit, then stable high
    for (int i = 0; i < 50; i++) begin
      right_limit_raw_i = (i % 2 == 0);
      idle(1);
    end
    check("right_during_bounce", 32'(right_limit_o), 32'h0);
    right_limit_raw_i = 1'b1;
    last = cyc;
    rise = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge sys_clk);
      if (right_limit_o) begin
        rise = cyc;
        break;
      end
    end
    @(posedge sys_clk);
    #1;
    lat = rise - last;
    n_vec++;
    if (rise < 0 || lat < int'(DB + 2) || lat > int'(DB + 3)) begin
      n_miss++;
      $display("FAIL right_latency: got %0d cycles expected %0d..%0d", lat, DB + 2, DB + 3);
    end

    // Reset mid-debounce restarts the count
    right_limit_raw_i = 1'b0;
    pulse_reset(2);
    check("right_after_reset", 32'(right_limit_o), 32'h0);
    right_limit_raw_i = 1'b1;
    idle(60);
    pulse_reset(2);
    idle(50);
    check("right_held_low", 32'(right_limit_o), 32'h0);
    idle(60);
    check("right_rises_again", 32'(right_limit_o), 32'h1);

    check("left_quiet", 32'(left_limit_o), 32'h0);
    idle(5);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
